// File: rtl/wasca_avmm_block_mover_pkg.sv
// Shared op codes and FSM state encoding for the AVMM block mover.
package wasca_avmm_block_mover_pkg;

  localparam logic [1:0] OP_FILL  = 2'b00;
  localparam logic [1:0] OP_COPY  = 2'b01;
  localparam logic [1:0] OP_CHECK = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CP_RD,
    ST_CP_WR,
    ST_CK_RD,
    ST_CK_LAST,
    ST_FIN
  } state_t;

endpackage

// File: rtl/wasca_avmm_range_ctr.sv
// Range walker: one word index added to a source and a destination base,
// plus a down-counter whose last flag marks the final word of the range.
// Everything freezes while en_i is low so a stalled bus resumes in place.
module wasca_avmm_range_ctr #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [AW:0]   len_i,
  output logic [AW-1:0] src_addr_o,
  output logic [AW-1:0] dst_addr_o,
  output logic          last_o
);

  logic [AW-1:0] src_q, dst_q, idx_q;
  logic [AW:0]   cnt_q;

  // Latch bases and count on command accept, then walk one word per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      if (load_i) begin
        src_q <= src_i;
        dst_q <= dst_i;
        idx_q <= '0;
        cnt_q <= len_i;
      end else if (step_i) begin
        idx_q <= idx_q + AW'(1);
        cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

  assign src_addr_o = src_q + idx_q;
  assign dst_addr_o = dst_q + idx_q;
  assign last_o     = (cnt_q == (AW+1)'(1));

endmodule

// File: rtl/wasca_avmm_block_mover.sv
// Avalon-MM master that fills, copies or checks a word range of a
// single-port on-chip RAM (read latency 1, clken-gated). One command at a time.
module wasca_avmm_block_mover
  import wasca_avmm_block_mover_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 2560
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW:0]   cmd_len,
  input  logic [31:0]   cmd_pattern,
  input  logic          hold,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mismatch_addr,
  output logic [AW-1:0] avm_address,
  output logic [3:0]    avm_byteenable,
  output logic          avm_chipselect,
  output logic          avm_write,
  output logic [31:0]   avm_writedata,
  output logic          avm_clken,
  output logic          avm_reset_req,
  input  logic [31:0]   avm_readdata
);

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  state_t        state_q;
  logic [31:0]   pat_q;
  logic          err_q;
  logic          cmp_vld_q;
  logic [AW-1:0] cmp_addr_q;
  logic [AW-1:0] mm_addr_q;

  logic          en, accept, step, last, range_bad, rd_miss;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW+1:0] dst_end, src_end;

  assign en     = ~hold;
  assign accept = (state_q == ST_IDLE) && cmd_valid && en;
  assign step   = (state_q == ST_FILL) || (state_q == ST_CP_WR) || (state_q == ST_CK_RD);

  // End addresses are computed two bits wider so a range can never wrap past zero
  assign dst_end   = {2'b00, cmd_dst} + {1'b0, cmd_len};
  assign src_end   = {2'b00, cmd_src} + {1'b0, cmd_len};
  assign range_bad = (cmd_op == OP_RSVD) || (dst_end > DEPTH_W) ||
                     ((cmd_op == OP_COPY) && (src_end > DEPTH_W));

  // Read data of the previous CHECK read is valid whenever cmp_vld_q is set
  assign rd_miss = cmp_vld_q && (avm_readdata != pat_q);

  wasca_avmm_range_ctr #(.AW(AW)) u_range (
    .clk        (clk),
    .rst        (reset),
    .en_i       (en),
    .load_i     (accept),
    .step_i     (step),
    .src_i      (cmd_src),
    .dst_i      (cmd_dst),
    .len_i      (cmd_len),
    .src_addr_o (src_addr),
    .dst_addr_o (dst_addr),
    .last_o     (last)
  );

  // Command sequencer: accept, walk the range, compare CHECK data, report
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      err_q      <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      mm_addr_q  <= '0;
    end else if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            pat_q     <= cmd_pattern;
            err_q     <= 1'b0;
            mm_addr_q <= '0;
            cmp_vld_q <= 1'b0;
            if (range_bad) begin
              err_q   <= 1'b1;
              state_q <= ST_FIN;
            end else if (cmd_len == '0) begin
              state_q <= ST_FIN;
            end else begin
              case (cmd_op)
                OP_FILL: state_q <= ST_FILL;
                OP_COPY: state_q <= ST_CP_RD;
                default: state_q <= ST_CK_RD;
              endcase
            end
          end
        end
        ST_FILL:  if (last) state_q <= ST_FIN;
        ST_CP_RD: state_q <= ST_CP_WR;
        ST_CP_WR: state_q <= last ? ST_FIN : ST_CP_RD;
        ST_CK_RD: begin
          if (rd_miss && !err_q) begin
            err_q     <= 1'b1;
            mm_addr_q <= cmp_addr_q;
          end
          cmp_vld_q  <= 1'b1;
          cmp_addr_q <= dst_addr;
          if (last) state_q <= ST_CK_LAST;
        end
        ST_CK_LAST: begin
          if (rd_miss && !err_q) begin
            err_q     <= 1'b1;
            mm_addr_q <= cmp_addr_q;
          end
          cmp_vld_q <= 1'b0;
          state_q   <= ST_FIN;
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus cycle decode; COPY writes the slave's read data straight back out
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    case (state_q)
      ST_FILL: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = dst_addr;
        avm_writedata  = pat_q;
      end
      ST_CP_RD: begin
        avm_chipselect = 1'b1;
        avm_address    = src_addr;
      end
      ST_CP_WR: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = dst_addr;
        avm_writedata  = avm_readdata;
      end
      ST_CK_RD: begin
        avm_chipselect = 1'b1;
        avm_address    = dst_addr;
      end
      default: ;
    endcase
  end

  // done is masked by hold so a stall in FIN postpones the single pulse
  assign done           = (state_q == ST_FIN) && en;
  assign err            = done && err_q;
  assign cmd_ready      = (state_q == ST_IDLE) && en;
  assign mismatch_addr  = mm_addr_q;
  assign avm_clken      = en;
  assign avm_byteenable = 4'hF;
  assign avm_reset_req  = 1'b0;

endmodule
